// File: rtl/preemption_reset_controller.sv
// Preemption/reset sequencer: quantum countdown, safe-point deferred switches, stretched CPU reset; `SAFE_POINT_TIMEOUT_EN adds a safe-wait timeout.
// Outputs registered (1-cycle latency); no backpressure, protected opcodes only defer a pending switch.
module preemption_reset_controller #(
  parameter int OPCODE_WIDTH      = 6,
  parameter int PC_WIDTH          = 12,
  parameter int OS_LIMIT          = 256,
  parameter int QUANTUM_WIDTH     = 32,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int PROCESS_COUNT     = 4,
  parameter int SAFE_TIMEOUT      = 16,
  localparam int PID_WIDTH        = (PROCESS_COUNT > 2) ? $clog2(PROCESS_COUNT) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [OPCODE_WIDTH-1:0]  operation,
  input  logic [PC_WIDTH-1:0]      program_counter,
  input  logic                     system_reset,
  input  logic                     resume_os,
  input  logic                     context_exchange,
  input  logic                     quantum_set,
  input  logic [QUANTUM_WIDTH-1:0] quantum_load,
  output logic                     reset_cpu,
  output logic                     jump_context_exchange,
  output logic [PID_WIDTH-1:0]     process_id,
  output logic                     quantum_expired,
  output logic                     switch_pending
);

  localparam int HOLD_WIDTH = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_INIT = HOLD_WIDTH'(RESET_HOLD_CYCLES);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SAFE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_SYS  = 2'd1;
  localparam logic [1:0] CAUSE_OS   = 2'd2;
  localparam logic [1:0] CAUSE_PRE  = 2'd3;

  localparam logic [OPCODE_WIDTH-1:0] OP_START = OPCODE_WIDTH'(6'b100111);

  if (RESET_HOLD_CYCLES < 1 || PROCESS_COUNT < 2 || SAFE_TIMEOUT < 1) begin : g_bad_params
    $error("preemption_reset_controller: illegal parameter value");
  end

  function automatic logic is_protected(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OPCODE_WIDTH'(6'b010101), OPCODE_WIDTH'(6'b100011), OPCODE_WIDTH'(6'b100001),
      OPCODE_WIDTH'(6'b100010), OPCODE_WIDTH'(6'b011111), OPCODE_WIDTH'(6'b010011),
      OPCODE_WIDTH'(6'b010100), OPCODE_WIDTH'(6'b011101), OPCODE_WIDTH'(6'b100000):
        is_protected = 1'b1;
      default: is_protected = 1'b0;
    endcase
  endfunction

  logic [1:0]               state;
  logic [1:0]               cause;
  logic [HOLD_WIDTH-1:0]    hold_cnt;
  logic [QUANTUM_WIDTH-1:0] quantum_cnt;
  logic                     in_os;
  logic                     start_sys;
  logic                     decrement;
  logic                     expire;
  logic                     os_req;
  logic                     safe_point;

  assign in_os      = program_counter < PC_WIDTH'(OS_LIMIT);
  assign start_sys  = operation == OP_START;
  assign decrement  = (state == ST_RUN) && (quantum_cnt != '0) && !in_os;
  // A reload in the expiry cycle cancels the preempt.
  assign expire     = decrement && (quantum_cnt == QUANTUM_WIDTH'(1)) && !quantum_set;
  assign os_req     = resume_os && in_os;
  assign switch_pending = state == ST_SAFE;

`ifdef SAFE_POINT_TIMEOUT_EN
  localparam int WAIT_WIDTH = $clog2(SAFE_TIMEOUT + 1);
  logic [WAIT_WIDTH-1:0] wait_cnt;
  assign safe_point = !is_protected(operation) || (wait_cnt == WAIT_WIDTH'(SAFE_TIMEOUT - 1));
`else
  assign safe_point = !is_protected(operation);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_BOOT;
      cause                 <= CAUSE_NONE;
      reset_cpu             <= 1'b1;
      jump_context_exchange <= 1'b0;
      process_id            <= '0;
      quantum_cnt           <= '0;
      quantum_expired       <= 1'b0;
      hold_cnt              <= HOLD_INIT;
`ifdef SAFE_POINT_TIMEOUT_EN
      wait_cnt              <= '0;
`endif
    end else begin
      jump_context_exchange <= context_exchange && (quantum_cnt != '0) &&
                               ((state == ST_RUN) || (state == ST_SAFE));

      if (quantum_set) begin
        quantum_cnt     <= quantum_load;
        quantum_expired <= 1'b0;
      end else if (decrement) begin
        quantum_cnt <= quantum_cnt - QUANTUM_WIDTH'(1);
        if (quantum_cnt == QUANTUM_WIDTH'(1)) quantum_expired <= 1'b1;
      end

      case (state)
        ST_BOOT: begin
          if (hold_cnt <= HOLD_WIDTH'(1)) begin
            state     <= ST_RUN;
            reset_cpu <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (start_sys) begin
            state     <= ST_HOLD;
            cause     <= CAUSE_NONE;
            reset_cpu <= 1'b1;
            hold_cnt  <= HOLD_INIT;
          end else if (system_reset || os_req || expire) begin
            state <= ST_SAFE;
            cause <= system_reset ? CAUSE_SYS : (os_req ? CAUSE_OS : CAUSE_PRE);
`ifdef SAFE_POINT_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_SAFE: begin
`ifdef SAFE_POINT_TIMEOUT_EN
          wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
`endif
          // start_system skips the safe point and keeps the current slot.
          if (start_sys || safe_point) begin
            state     <= ST_HOLD;
            reset_cpu <= 1'b1;
            hold_cnt  <= HOLD_INIT;
            if (start_sys) cause <= CAUSE_NONE;
          end
        end
        ST_HOLD: begin
          if (start_sys) begin
            hold_cnt <= HOLD_INIT;
          end else if (hold_cnt <= HOLD_WIDTH'(1)) begin
            state     <= ST_RUN;
            reset_cpu <= 1'b0;
            if (cause == CAUSE_SYS) begin
              process_id <= '0;
            end else if (cause == CAUSE_PRE) begin
              process_id <= (process_id == PID_WIDTH'(PROCESS_COUNT - 1)) ? '0
                                                                          : process_id + PID_WIDTH'(1);
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_preemption_reset_controller.sv
// Bench for preemption_reset_controller: vector table, directed corner sequences, randomized run against a reference model.
module tb_preemption_reset_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  operation = '0;
  logic [11:0] program_counter = 12'd300;
  logic        system_reset = 1'b0, resume_os = 1'b0, context_exchange = 1'b0, quantum_set = 1'b0;
  logic [31:0] quantum_load = '0;
  logic        reset_cpu, jump_context_exchange, quantum_expired, switch_pending;
  logic [1:0]  process_id;

  preemption_reset_controller dut (
    .clock(clock), .reset_n(reset_n), .operation(operation), .program_counter(program_counter),
    .system_reset(system_reset), .resume_os(resume_os), .context_exchange(context_exchange),
    .quantum_set(quantum_set), .quantum_load(quantum_load), .reset_cpu(reset_cpu),
    .jump_context_exchange(jump_context_exchange), .process_id(process_id),
    .quantum_expired(quantum_expired), .switch_pending(switch_pending)
  );

  always #5 clock = ~clock;

`ifdef SAFE_POINT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: remaining reset cycles, a pending-switch flag and the reason it was raised.
  int unsigned m_quantum;
  bit          m_expired, m_booting, m_waiting, m_jxe;
  int          m_pid, m_reset_left, m_wait_cycles;
  string       m_reason;

  function automatic bit prot(input logic [5:0] op);
    return op inside {6'b010101, 6'b100011, 6'b100001, 6'b100010, 6'b011111,
                      6'b010011, 6'b010100, 6'b011101, 6'b100000};
  endfunction

  function automatic void model_reset();
    m_quantum = 0; m_expired = 0; m_pid = 0; m_reset_left = 2; m_booting = 1;
    m_waiting = 0; m_reason = "none"; m_wait_cycles = 0; m_jxe = 0;
  endfunction

  function automatic void model_step();
    bit start, active, ticking, expiry;
    start   = (operation == 6'b100111);
    active  = (m_reset_left == 0);
    ticking = active && !m_waiting && m_quantum != 0 && program_counter >= 256;
    expiry  = ticking && m_quantum == 1 && !quantum_set;
    m_jxe   = context_exchange && m_quantum != 0 && active;
    if (quantum_set) begin
      m_quantum = quantum_load; m_expired = 0;
    end else if (ticking) begin
      m_quantum--;
      if (m_quantum == 0) m_expired = 1;
    end
    if (m_booting) begin
      m_reset_left--;
      if (m_reset_left == 0) m_booting = 0;
    end else if (m_reset_left > 0) begin
      if (start) m_reset_left = 2;
      else begin
        m_reset_left--;
        if (m_reset_left == 0) begin
          if (m_reason == "system") m_pid = 0;
          else if (m_reason == "preempt") m_pid = (m_pid + 1) % 4;
        end
      end
    end else if (m_waiting) begin
      m_wait_cycles++;
      if (start) begin
        m_reason = "none"; m_waiting = 0; m_reset_left = 2;
      end else if (!prot(operation) || (TIMEOUT_EN && m_wait_cycles >= 16)) begin
        m_waiting = 0; m_reset_left = 2;
      end
    end else if (start) begin
      m_reason = "none"; m_reset_left = 2;
    end else if (system_reset || (resume_os && program_counter < 256) || expiry) begin
      m_waiting = 1; m_wait_cycles = 0;
      m_reason = system_reset ? "system" : ((resume_os && program_counter < 256) ? "os" : "preempt");
    end
  endfunction

  function automatic logic [5:0] dut_bits();
    return {reset_cpu, jump_context_exchange, process_id, quantum_expired, switch_pending};
  endfunction

  function automatic logic [5:0] model_bits();
    return {m_reset_left > 0, m_jxe, 2'(m_pid), m_expired, m_waiting};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [11:0] pc, input logic sr, input logic ro,
                       input logic cx, input logic qs, input logic [31:0] ql);
    operation = op; program_counter = pc; system_reset = sr; resume_os = ro;
    context_exchange = cx; quantum_set = qs; quantum_load = ql;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("model", 32'(dut_bits()), 32'(model_bits()));
  endtask

  task automatic idle(input int n);
    drive(6'b000000, 12'd300, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Load quantum 1 so the next RUN cycle at a user PC preempts; ends back in RUN.
  task automatic preempt(input int exp_pid);
    drive(6'b000000, 12'd300, 0, 0, 0, 1, 1); tick();
    idle(1);
    check("preempt_pending", 32'(switch_pending), 32'd1);
    idle(3);
    check("preempt_pid", 32'(process_id), 32'(exp_pid));
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [11:0] pc;
    logic        sr, ro, cx, qs;
    logic [31:0] ql;
    logic [5:0]  exp;  // {reset_cpu, jump_context_exchange, process_id, quantum_expired, switch_pending}
  } vec_t;

  vec_t vecs[$];
  int   pend_cnt;

  initial begin
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0,  6'b100000});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0,  6'b000000});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 1, 5,  6'b000000});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0, 6'b000000});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0,  6'b000011});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0,  6'b100010});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0,  6'b100010});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 0, 0, 0,  6'b000110});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 1, 0, 0,  6'b000110});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 1, 1, 10, 6'b000100});
    vecs.push_back('{6'b000000, 12'd300, 0, 0, 1, 0, 0,  6'b010100});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{6'b010101, 12'd100, 0, 1, 0, 0, 0, 6'b000101});
    vecs.push_back('{6'b000001, 12'd100, 0, 0, 0, 0, 0,  6'b100100});
    vecs.push_back('{6'b000001, 12'd100, 0, 0, 0, 0, 0,  6'b100100});
    vecs.push_back('{6'b000001, 12'd100, 0, 0, 0, 0, 0,  6'b000100});

    // Reset state
    model_reset();
    @(negedge clock); @(negedge clock);
    check("reset_values", 32'(dut_bits()), 32'(6'b100000));
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].pc, vecs[i].sr, vecs[i].ro, vecs[i].cx, vecs[i].qs, vecs[i].ql);
      tick();
      check($sformatf("vec%0d", i), 32'(dut_bits()), 32'(vecs[i].exp));
    end

    // start_system while waiting on branchz, then again inside HOLD
    drive(6'b010011, 12'd300, 1, 0, 0, 0, 0); tick();
    check("sw_on_branchz", 32'(switch_pending), 32'd1);
    drive(6'b010011, 12'd300, 0, 0, 0, 0, 0); tick();
    check("sw_stays", 32'(switch_pending), 32'd1);
    drive(6'b100111, 12'd300, 0, 0, 0, 0, 0); tick();
    check("start_hold1", 32'({reset_cpu, switch_pending}), 32'(2'b10));
    tick();
    check("start_restart", 32'(reset_cpu), 32'd1);
    idle(1);
    check("start_hold_tail", 32'(reset_cpu), 32'd1);
    idle(1);
    check("start_release", 32'(reset_cpu), 32'd0);
    check("start_pid_kept", 32'(process_id), 32'd1);

    // Preempt rotation with wrap, then system_reset clears the slot
    preempt(2);
    preempt(3);
    preempt(0);
    preempt(1);
    drive(6'b000000, 12'd300, 1, 0, 0, 0, 0); tick();
    idle(3);
    check("sysreset_pid", 32'(process_id), 32'd0);

    // Reload in the expiry cycle wins; a zero load disables preemption
    drive(6'b000000, 12'd300, 0, 0, 0, 1, 2); tick();
    idle(1);
    drive(6'b000000, 12'd300, 0, 0, 0, 1, 7); tick();
    check("reload_wins", 32'({quantum_expired, switch_pending}), 32'd0);
    drive(6'b000000, 12'd300, 0, 0, 0, 1, 0); tick();
    idle(10);
    check("zero_quantum", 32'({quantum_expired, switch_pending}), 32'd0);

    // Safe-wait held on loadr
    drive(6'b000000, 12'd300, 0, 0, 0, 1, 1); tick();
    drive(6'b100001, 12'd300, 0, 0, 0, 0, 0); tick();
    pend_cnt = switch_pending ? 1 : 0;
    for (int i = 0; i < 100 && switch_pending; i++) begin
      tick();
      if (switch_pending) pend_cnt++;
    end
    check("safe_wait_len", 32'(pend_cnt), TIMEOUT_EN ? 32'd16 : 32'd101);
    idle(4);

    // Asynchronous reset in the middle of HOLD
    preempt(2);
    drive(6'b000000, 12'd300, 1, 0, 0, 0, 0); tick();
    idle(1);
    #1 reset_n = 1'b0;
    #1 check("async_reset", 32'(dut_bits()), 32'(6'b100000));
    model_reset();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 29);
      if (sel == 0) op = 6'b100111;
      else if (sel < 14) begin
        case ($urandom_range(0, 8))
          0: op = 6'b010101; 1: op = 6'b100011; 2: op = 6'b100001;
          3: op = 6'b100010; 4: op = 6'b011111; 5: op = 6'b010011;
          6: op = 6'b010100; 7: op = 6'b011101; default: op = 6'b100000;
        endcase
      end else op = 6'($urandom);
      drive(op, 12'($urandom_range(0, 511)), $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 14) == 0,
            32'($urandom_range(0, 12)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
